// File: rtl/dbg_host_pkg.sv
// Shared types and constants for the debug-port host controller.
package dbg_host_pkg;

    localparam int unsigned DBG_ADDR_W = 7;
    localparam int unsigned DBG_DATA_W = 32;
    localparam int unsigned DBG_NREG   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StStepHi,
        StStepLo,
        StScan
    } dbg_state_e;

endpackage

// File: rtl/dbg_snap_buf.sv
// Register snapshot buffer: one synchronous write port, one combinational read port, no reset.
module dbg_snap_buf
    import dbg_host_pkg::*;
#(
    parameter int unsigned NREG = DBG_NREG
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DBG_DATA_W-1:0] wdata,
    input  logic [4:0]            raddr,
    output logic [DBG_DATA_W-1:0] rdata
);

    logic [DBG_DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Indices past NREG read as zero when the buffer is built smaller than 32.
    always_comb begin
        rdata = '0;
        if ({27'b0, raddr} < NREG) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/dbg_step_host.sv
// Halts, single-steps and snapshots x0..x31 of the core through its debug port.
// Define DBG_AUTO_SCAN_EN to follow every completed step directly with a register scan.
module dbg_step_host
    import dbg_host_pkg::*;
#(
    parameter int unsigned STEP_HOLD = 4,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned NREG      = DBG_NREG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic                  scan_req,
    output logic                  debug_en,
    output logic                  debug_step,
    output logic [DBG_ADDR_W-1:0] debug_addr,
    input  logic [DBG_DATA_W-1:0] debug_data,
    input  logic [4:0]            rd_idx,
    output logic [DBG_DATA_W-1:0] rd_data,
    output logic                  snap_valid,
    output logic                  busy,
    output logic [31:0]           step_count,
    output logic                  req_overrun
);

    localparam logic [15:0] HoldLast   = 16'(STEP_HOLD - 1);
    localparam logic [15:0] SettleLast = 16'(SETTLE);
    localparam logic [4:0]  IdxLast    = 5'(NREG - 1);

    dbg_state_e            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [4:0]            idx_q, idx_d;
    logic                  en_q, en_d;
    logic                  step_q, step_d;
    logic [DBG_ADDR_W-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic [31:0]           count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  step_pend_q, step_pend_d;
    logic                  scan_pend_q, scan_pend_d;
    logic                  step_go, scan_go, snap_we;

    assign step_go = step_req | step_pend_q;
    assign scan_go = scan_req | scan_pend_q;
    assign snap_we = (state_q == StScan) && (cnt_q == SettleLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        en_d        = en_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        step_pend_d = step_pend_q;
        scan_pend_d = scan_pend_q;

        // A request arriving while its one-deep slot is full is lost.
        if (step_req && step_pend_q) overrun_d = 1'b1;
        if (scan_req && scan_pend_q) overrun_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                en_d        = halt_req;
                step_pend_d = 1'b0;
                if (step_go && en_q) begin
                    state_d     = StStepHi;
                    cnt_d       = '0;
                    scan_pend_d = scan_go;
                end else if (scan_go) begin
                    state_d     = StScan;
                    scan_pend_d = 1'b0;
                    cnt_d       = '0;
                    idx_d       = '0;
                    addr_d      = '0;
                    valid_d     = 1'b0;
                end
            end
            StStepHi: begin
                if (step_req && !step_pend_q) step_pend_d = 1'b1;
                if (scan_req && !scan_pend_q) scan_pend_d = 1'b1;
                if (cnt_q == HoldLast) begin
                    state_d = StStepLo;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStepLo: begin
                if (step_req && !step_pend_q) step_pend_d = 1'b1;
                if (scan_req && !scan_pend_q) scan_pend_d = 1'b1;
                if (cnt_q == HoldLast) begin
                    count_d = count_q + 32'd1;
`ifdef DBG_AUTO_SCAN_EN
                    state_d = StScan;
                    cnt_d   = '0;
                    idx_d   = '0;
                    addr_d  = '0;
                    valid_d = 1'b0;
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StScan: begin
                if (step_req && !step_pend_q) step_pend_d = 1'b1;
                if (scan_req && !scan_pend_q) scan_pend_d = 1'b1;
                if (cnt_q == SettleLast) begin
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d = StIdle;
                        valid_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 5'd1;
                        addr_d = {2'b00, idx_d};
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        step_d = (state_d == StStepHi);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            en_q        <= 1'b0;
            step_q      <= 1'b0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            step_pend_q <= 1'b0;
            scan_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            step_q      <= step_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            step_pend_q <= step_pend_d;
            scan_pend_q <= scan_pend_d;
        end
    end

    dbg_snap_buf #(
        .NREG (NREG)
    ) u_snap_buf (
        .clk   (clk),
        .we    (snap_we),
        .waddr (idx_q),
        .wdata (debug_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign debug_en    = en_q;
    assign debug_step  = step_q;
    assign debug_addr  = addr_q;
    assign snap_valid  = valid_q;
    assign busy        = busy_q;
    assign step_count  = count_q;
    assign req_overrun = overrun_q;

endmodule

// File: tb/tb_dbg_step_host.sv
// Self-checking bench for dbg_step_host with a salted core model (debug_data = {salt[31:7], debug_addr}).
module tb_dbg_step_host;

    localparam int unsigned STEP_HOLD = 2;
    localparam int unsigned SETTLE    = 1;
    localparam int unsigned NREG      = 32;
    localparam int unsigned SCAN_CYC  = NREG * (SETTLE + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        scan_req = 1'b0;
    logic [4:0]  rd_idx = 5'd0;
    logic        debug_en, debug_step, snap_valid, busy, req_overrun;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data, rd_data, step_count;
    logic [31:0] core_salt = 32'hA000_0000;

    assign debug_data = {core_salt[31:7], debug_addr};

    always #5 clk = ~clk;

    dbg_step_host #(
        .STEP_HOLD (STEP_HOLD),
        .SETTLE    (SETTLE),
        .NREG      (NREG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .scan_req    (scan_req),
        .debug_en    (debug_en),
        .debug_step  (debug_step),
        .debug_addr  (debug_addr),
        .debug_data  (debug_data),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .snap_valid  (snap_valid),
        .busy        (busy),
        .step_count  (step_count),
        .req_overrun (req_overrun)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] snap_model [NREG];
    logic [31:0] exp_count = 32'd0;

    // Pulse monitor: counts step pulses and flags any high phase not STEP_HOLD long.
    int   rise_cnt = 0;
    int   width_err = 0;
    int   high_len = 0;
    logic prev_step = 1'b0;
    always @(negedge clk) begin
        if (debug_step === 1'b1) begin
            if (prev_step !== 1'b1) begin
                rise_cnt <= rise_cnt + 1;
                high_len <= 1;
            end else begin
                high_len <= high_len + 1;
            end
        end else if (prev_step === 1'b1) begin
            if (high_len != STEP_HOLD) width_err <= width_err + 1;
            high_len <= 0;
        end
        prev_step <= debug_step;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_model(input logic [31:0] salt);
        for (int i = 0; i < NREG; i++) snap_model[i] = {salt[31:7], 7'(i)};
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 2000) begin
            tick();
            n++;
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
        end
        checks++;
        if (quiet < 4) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks += 7;
        if (debug_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", debug_en); end
        if (debug_step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", debug_step); end
        if (debug_addr !== 7'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", debug_addr); end
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", snap_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (step_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", step_count); end
        if (req_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", req_overrun); end
        rst = 1'b0;
    endtask

    task automatic test_single_step;
        logic [7:0] seen, want;
        int busy_bad = 0;
        halt_req = 1'b1;
        tick();
        tick();
        checks++;
        if (debug_en !== 1'b1) begin errors++; $display("FAIL step_en: got %b want 1", debug_en); end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        seen = '0;
        want = '0;
        for (int c = 1; c <= 2 * STEP_HOLD; c++) begin
            seen[c-1] = debug_step;
            want[c-1] = (c <= STEP_HOLD);
            if (busy !== 1'b1) busy_bad++;
            if (c < 2 * STEP_HOLD) tick();
        end
        checks += 3;
        if (seen !== want) begin errors++; $display("FAIL step_pulse: got %b want %b", seen, want); end
        if (busy_bad != 0) begin errors++; $display("FAIL step_busy: %0d low cycles, want 0", busy_bad); end
        if (step_count !== exp_count) begin
            errors++; $display("FAIL step_early_count: got %0d want %0d", step_count, exp_count);
        end
        tick();
        exp_count++;
        checks += 2;
        if (step_count !== exp_count) begin
            errors++; $display("FAIL step_count: got %0d want %0d", step_count, exp_count);
        end
        if (debug_step !== 1'b0) begin errors++; $display("FAIL step_after: got %b want 0", debug_step); end
`ifndef DBG_AUTO_SCAN_EN
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL step_busy_fall: got %b want 0", busy); end
`endif
        wait_idle("step");
    endtask

    task automatic test_scan(input logic [31:0] salt, input int ri, input bit check_old);
        logic [31:0] old_val;
        int n = 0;
        int addr_bad = 0;
        int bad = 0;
        int off;
        core_salt = salt;
        rd_idx = 5'(ri);
        old_val = snap_model[ri];
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        checks += 2;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL scan_entry_valid: got %b want 0", snap_valid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL scan_entry_busy: got %b want 1", busy); end
        while (snap_valid !== 1'b1 && n < 4 * SCAN_CYC) begin
            if (n < SCAN_CYC && debug_addr !== 7'(n / (SETTLE + 1))) addr_bad++;
            if (check_old && n == ri * (SETTLE + 1) + SETTLE) begin
                checks++;
                if (rd_data !== old_val) begin
                    errors++; $display("FAIL scan_read_old[%0d]: got %h want %h", ri, rd_data, old_val);
                end
            end
            tick();
            n++;
        end
        load_model(salt);
        checks += 3;
        if (n != SCAN_CYC) begin errors++; $display("FAIL scan_latency: got %0d want %0d", n, SCAN_CYC); end
        if (addr_bad != 0) begin errors++; $display("FAIL scan_addr: %0d bad cycles, want 0", addr_bad); end
        if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy_end: got %b want 0", busy); end
        rd_idx = 5'd5;
        tick();
        checks++;
        if (rd_data !== snap_model[5]) begin
            errors++; $display("FAIL scan_rd5: got %h want %h", rd_data, snap_model[5]);
        end
        rd_idx = 5'd31;
        tick();
        checks++;
        if (rd_data !== snap_model[31]) begin
            errors++; $display("FAIL scan_rd31: got %h want %h", rd_data, snap_model[31]);
        end
        checks++;
        if (debug_addr !== 7'(NREG - 1)) begin
            errors++; $display("FAIL scan_addr_hold: got %h want %h", debug_addr, 7'(NREG - 1));
        end
        off = $urandom_range(0, NREG - 1);
        for (int i = 0; i < NREG; i++) begin
            rd_idx = 5'((i + off) % NREG);
            tick();
            if (rd_data !== snap_model[(i + off) % NREG]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL scan_readback: %0d bad words, want 0", bad); end
    endtask

    task automatic test_step_no_halt;
        int act = 0;
        int r0;
        halt_req = 1'b0;
        tick();
        tick();
        r0 = rise_cnt;
        checks++;
        if (debug_en !== 1'b0) begin errors++; $display("FAIL nohalt_en: got %b want 0", debug_en); end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (debug_step !== 1'b0 || busy !== 1'b0) act++;
            tick();
        end
        checks += 4;
        if (act != 0) begin errors++; $display("FAIL nohalt_activity: %0d active cycles, want 0", act); end
        if (rise_cnt != r0) begin errors++; $display("FAIL nohalt_pulses: got %0d want 0", rise_cnt - r0); end
        if (step_count !== exp_count) begin
            errors++; $display("FAIL nohalt_count: got %0d want %0d", step_count, exp_count);
        end
        if (req_overrun !== 1'b0) begin errors++; $display("FAIL nohalt_overrun: got %b want 0", req_overrun); end
    endtask

    task automatic test_halt_drop;
        halt_req = 1'b1;
        tick();
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        halt_req = 1'b0;
        tick();
        tick();
        checks++;
        if (debug_en !== 1'b1) begin errors++; $display("FAIL drop_en_mid: got %b want 1", debug_en); end
        wait_idle("drop");
        exp_count++;
        checks += 2;
        if (step_count !== exp_count) begin
            errors++; $display("FAIL drop_count: got %0d want %0d", step_count, exp_count);
        end
        if (debug_en !== 1'b0) begin errors++; $display("FAIL drop_en_end: got %b want 0", debug_en); end
    endtask

    task automatic test_overrun;
        int r0;
        halt_req = 1'b1;
        tick();
        tick();
        r0 = rise_cnt;
        step_req = 1'b1;
        tick();
        tick();
        tick();
        step_req = 1'b0;
        wait_idle("overrun");
        exp_count += 2;
        checks += 3;
        if (rise_cnt - r0 != 2) begin errors++; $display("FAIL overrun_pulses: got %0d want 2", rise_cnt - r0); end
        if (step_count !== exp_count) begin
            errors++; $display("FAIL overrun_count: got %0d want %0d", step_count, exp_count);
        end
        if (req_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", req_overrun); end
    endtask

    task automatic test_random_steps;
        int n;
        int r0;
        int w0;
        int bad = 0;
        bit any_scan = 1'b0;
        bit do_scan;
        logic [31:0] salt;
        n = $urandom_range(3, 8);
        r0 = rise_cnt;
        w0 = width_err;
        halt_req = 1'b1;
        tick();
        tick();
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) tick();
            do_scan = 1'($urandom_range(0, 1));
            salt = $urandom();
            core_salt = salt;
            step_req = 1'b1;
            scan_req = do_scan;
            tick();
            step_req = 1'b0;
            scan_req = 1'b0;
            wait_idle("rand");
            exp_count++;
`ifdef DBG_AUTO_SCAN_EN
            load_model(salt);
            any_scan = 1'b1;
`else
            if (do_scan) begin
                load_model(salt);
                any_scan = 1'b1;
            end
`endif
        end
        checks += 3;
        if (step_count !== exp_count) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", step_count, exp_count);
        end
        if (rise_cnt - r0 != n) begin errors++; $display("FAIL rand_pulses: got %0d want %0d", rise_cnt - r0, n); end
        if (width_err != w0) begin errors++; $display("FAIL rand_width: %0d bad pulses, want 0", width_err - w0); end
        if (any_scan) begin
            for (int i = 0; i < NREG; i++) begin
                rd_idx = 5'(i);
                tick();
                if (rd_data !== snap_model[i]) bad++;
            end
            checks += 2;
            if (bad != 0) begin errors++; $display("FAIL rand_snap: %0d bad words, want 0", bad); end
            if (snap_valid !== 1'b1) begin errors++; $display("FAIL rand_valid: got %b want 1", snap_valid); end
        end
    endtask

    task automatic test_reset_mid_step;
        halt_req = 1'b1;
        tick();
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        checks++;
        if (debug_step !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", debug_step); end
        rst = 1'b1;
        tick();
        checks += 5;
        if (debug_step !== 1'b0) begin errors++; $display("FAIL midrst_step: got %b want 0", debug_step); end
        if (step_count !== 32'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", step_count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", snap_valid); end
        if (req_overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", req_overrun); end
        rst = 1'b0;
        exp_count = 32'd0;
`ifdef DBG_AUTO_SCAN_EN
        begin
            int n = 0;
            tick();
            tick();
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            checks++;
            if (snap_valid !== 1'b0) begin errors++; $display("FAIL auto_valid_pre: got %b want 0", snap_valid); end
            while (snap_valid !== 1'b1 && n < 500) begin
                tick();
                n++;
            end
            checks += 2;
            if (snap_valid !== 1'b1) begin errors++; $display("FAIL auto_valid: got %b want 1", snap_valid); end
            if (step_count !== 32'd1) begin errors++; $display("FAIL auto_count: got %0d want 1", step_count); end
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_step();
        test_scan(32'hA000_0000, $urandom_range(0, NREG - 2), 1'b0);
        test_scan($urandom(), $urandom_range(0, NREG - 2), 1'b1);
        test_step_no_halt();
        test_halt_drop();
        test_overrun();
        test_random_steps();
        test_reset_mid_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
